// File: rtl/bf_axi_lite_master.sv
// bf_axi_lite_master
// Single-outstanding AXI4-Lite initiator for the bf_16x16 slave. A valid/ready
// command (read or write of one word at a word offset) becomes exactly one
// AXI4-Lite transaction. The result comes back as one response beat carrying
// read data and the slave's BRESP/RRESP. Every output comes from a register.
// STAT_HUNG is a sticky flag. It rises when any single wait phase stalls for
// C_HANG_LIMIT cycles, and it clears on the next command accept.

module bf_axi_lite_master #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASEADDR         = 'h77a00000,
  parameter int                            C_OFFSET_WIDTH     = 7,
  parameter int                            C_HANG_LIMIT       = 8
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  // command stream
  input  logic                              CMD_VALID,
  output logic                              CMD_READY,
  input  logic                              CMD_WRITE,
  input  logic [C_OFFSET_WIDTH-1:0]         CMD_OFFSET,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
  // response stream
  output logic                              RSP_VALID,
  input  logic                              RSP_READY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
  output logic [1:0]                        RSP_RESP,
  output logic                              STAT_HUNG,
  // write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // write response channel
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int OW = C_OFFSET_WIDTH;
  localparam int CW = $clog2(C_HANG_LIMIT + 1);
  localparam logic [CW-1:0] HANG_LIMIT_C = CW'(C_HANG_LIMIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_B_WAIT = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_R_WAIT = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_resp_q, rsp_resp_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] hang_cnt_q, hang_cnt_d;
  logic          hung_q, hung_d;

  logic [AW-1:0] cmd_addr;
  logic          cmd_accept;
  logic          aw_pending;
  logic          w_pending;
  logic          b_hs;
  logic          ar_hs;
  logic          r_hs;
  logic          rsp_hs;
  logic          phase_entry;
  logic          phase_stall;

  // The byte address is the base with the word offset shifted into bits [OW+1:2].
  assign cmd_addr = C_BASEADDR | {{(AW-OW-2){1'b0}}, CMD_OFFSET, 2'b00};

  // CMD_READY is only ever high in IDLE, so a handshake alone marks an accept.
  assign cmd_accept = cmd_ready_q & CMD_VALID;
  assign aw_pending = awvalid_q & ~M_AXI_AWREADY;
  assign w_pending  = wvalid_q & ~M_AXI_WREADY;
  assign b_hs       = bready_q & M_AXI_BVALID;
  assign ar_hs      = arvalid_q & M_AXI_ARREADY;
  assign r_hs       = rready_q & M_AXI_RVALID;
  assign rsp_hs     = rsp_valid_q & RSP_READY;

  function automatic logic is_wait_state(input logic [2:0] s);
    return (s == S_WRITE) || (s == S_B_WAIT) || (s == S_READ) || (s == S_R_WAIT);
  endfunction

  assign phase_entry = (state_d != state_q) && is_wait_state(state_d);
  assign phase_stall = is_wait_state(state_q) && (state_d == state_q);

  // Transaction sequencing: one command at a time, through to its response beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          state_d = CMD_WRITE ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (!aw_pending && !w_pending) begin
          state_d = S_B_WAIT;
        end
      end
      S_B_WAIT: begin
        if (b_hs) begin
          state_d = S_RESP;
        end
      end
      S_READ: begin
        if (ar_hs) begin
          state_d = S_R_WAIT;
        end
      end
      S_R_WAIT: begin
        if (r_hs) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_hs) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags: each VALID/READY drops only on its own handshake and is raised on phase entry.
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    awvalid_d   = aw_pending;
    wvalid_d    = w_pending;
    arvalid_d   = arvalid_q & ~M_AXI_ARREADY;
    bready_d    = bready_q & ~M_AXI_BVALID;
    rready_d    = rready_q & ~M_AXI_RVALID;
    rsp_valid_d = rsp_valid_q & ~RSP_READY;
    if (cmd_accept) begin
      if (CMD_WRITE) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
      end else begin
        arvalid_d = 1'b1;
      end
    end
    if ((state_q == S_WRITE) && (state_d == S_B_WAIT)) begin
      bready_d = 1'b1;
    end
    if ((state_q == S_READ) && (state_d == S_R_WAIT)) begin
      rready_d = 1'b1;
    end
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      rsp_valid_d = 1'b1;
    end
  end

  // Address/data latching on accept, and response capture from the B or R beat.
  always_comb begin
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    if (cmd_accept) begin
      if (CMD_WRITE) begin
        awaddr_d = cmd_addr;
        wdata_d  = CMD_WDATA;
      end else begin
        araddr_d = cmd_addr;
      end
    end
    if ((state_q == S_B_WAIT) && b_hs) begin
      rsp_rdata_d = '0;
      rsp_resp_d  = M_AXI_BRESP;
    end
    if ((state_q == S_R_WAIT) && r_hs) begin
      rsp_rdata_d = M_AXI_RDATA;
      rsp_resp_d  = M_AXI_RRESP;
    end
  end

  // Hang watchdog: count stalled cycles in the current wait phase, saturating at the limit.
  always_comb begin
    hang_cnt_d = hang_cnt_q;
    hung_d     = hung_q;
    if (cmd_accept) begin
      hung_d = 1'b0;
    end
    if (phase_entry) begin
      hang_cnt_d = '0;
    end else if (phase_stall && (hang_cnt_q != HANG_LIMIT_C)) begin
      hang_cnt_d = hang_cnt_q + 1'b1;
      if ((hang_cnt_q + 1'b1) == HANG_LIMIT_C) begin
        hung_d = 1'b1;
      end
    end
  end

  // State register; reset abandons any in-flight transaction and drops every VALID/READY.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      hang_cnt_q  <= '0;
      hung_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      hang_cnt_q  <= hang_cnt_d;
      hung_q      <= hung_d;
    end
  end

  assign CMD_READY     = cmd_ready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;
  assign STAT_HUNG     = hung_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_bf_axi_lite_master.sv
// tb_bf_axi_lite_master
// Bench for bf_axi_lite_master. The bench acts as the AXI4-Lite slave, with
// programmable per-channel stall counts and response codes, and keeps a word
// memory as the reference model. Expected latency, hang status, addresses and
// read data are worked out from the transaction rules and the chosen delays.

module tb_bf_axi_lite_master;

  localparam logic [31:0] BASE       = 32'h77A00000;
  localparam int          HANG_LIMIT = 8;

  logic        clock = 1'b0;
  logic        areset;
  logic        cmdValid, cmdReady, cmdWrite;
  logic [6:0]  cmdOffset;
  logic [31:0] cmdWdata;
  logic        rspValid, rspReady, statHung;
  logic [31:0] rspRdata;
  logic [1:0]  rspResp;
  logic [31:0] awAddr, wData, arAddr, rData;
  logic [3:0]  wStrb;
  logic        awValid, awReady, wValid, wReady, bValid, bReady;
  logic        arValid, arReady, rValid, rReady;
  logic [1:0]  bResp, rResp;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] refMem   [128];
  logic [31:0] slaveMem [128];

  int          obsLat, obsProto, obsHungFirst, obsAwHi, obsWHi, obsArHi;
  bit          obsTimeout, obsHungRsp, obsHungC1, obsRspAfter, obsCmdReadyAfter;
  logic [31:0] obsRdata, obsAddr, obsWdata;
  logic [1:0]  obsResp;

  always #5 clock = ~clock;

  bf_axi_lite_master dut (
    .M_AXI_ACLK    (clock),
    .M_AXI_ARESET  (areset),
    .CMD_VALID     (cmdValid),
    .CMD_READY     (cmdReady),
    .CMD_WRITE     (cmdWrite),
    .CMD_OFFSET    (cmdOffset),
    .CMD_WDATA     (cmdWdata),
    .RSP_VALID     (rspValid),
    .RSP_READY     (rspReady),
    .RSP_RDATA     (rspRdata),
    .RSP_RESP      (rspResp),
    .STAT_HUNG     (statHung),
    .M_AXI_AWADDR  (awAddr),
    .M_AXI_AWVALID (awValid),
    .M_AXI_AWREADY (awReady),
    .M_AXI_WDATA   (wData),
    .M_AXI_WSTRB   (wStrb),
    .M_AXI_WVALID  (wValid),
    .M_AXI_WREADY  (wReady),
    .M_AXI_BRESP   (bResp),
    .M_AXI_BVALID  (bValid),
    .M_AXI_BREADY  (bReady),
    .M_AXI_ARADDR  (arAddr),
    .M_AXI_ARVALID (arValid),
    .M_AXI_ARREADY (arReady),
    .M_AXI_RDATA   (rData),
    .M_AXI_RRESP   (rResp),
    .M_AXI_RVALID  (rValid),
    .M_AXI_RREADY  (rReady)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one command and play the slave with the given stalls; record what the master did.
  task automatic applyStimulus(input bit wr, input logic [6:0] off, input logic [31:0] data,
                               input int awD, input int wD, input int bD, input int arD,
                               input int rD, input logic [1:0] resp, input int hold);
    int c, awCnt, wCnt, arCnt, bCnt, rCnt, holdCnt;
    bit awDone, wDone, arDone, bDone, rDone, rspSeen, fin;
    logic [31:0] awAddrL, wDataL, arAddrL, snapData;
    logic [1:0] snapResp;
    awCnt = 0; wCnt = 0; arCnt = 0; bCnt = 0; rCnt = 0; holdCnt = 0;
    awDone = 0; wDone = 0; arDone = 0; bDone = 0; rDone = 0; rspSeen = 0; fin = 0;
    awAddrL = '0; wDataL = '0; arAddrL = '0; snapData = '0; snapResp = '0;
    obsLat = -1; obsProto = 0; obsHungFirst = -1; obsAwHi = 0; obsWHi = 0; obsArHi = 0;
    obsTimeout = 0; obsHungRsp = 0; obsHungC1 = 0; obsRspAfter = 0; obsCmdReadyAfter = 0;
    obsRdata = '0; obsAddr = '0; obsWdata = '0; obsResp = '0;
    c = 0;
    while (!cmdReady && c < 20) begin
      tick();
      c++;
    end
    if (!cmdReady) begin
      obsTimeout = 1;
      return;
    end
    cmdValid = 1; cmdWrite = wr; cmdOffset = off; cmdWdata = data;
    tick();
    cmdValid = 0; cmdWrite = 0; cmdOffset = 7'($urandom); cmdWdata = $urandom;
    c = 1;
    obsHungC1 = statHung;
    while (!fin && c < 150) begin
      awReady = 0; wReady = 0; arReady = 0; rspReady = 0;
      if (cmdReady) obsProto++;
      if (statHung && obsHungFirst < 0) obsHungFirst = c;
      if (bReady && (!wr || !(awDone && wDone) || bDone)) obsProto++;
      if (wr) begin
        if (bDone) bValid = 0;
        else if (awDone && wDone) begin
          if (bCnt >= bD) begin
            bValid = 1;
            bResp = resp;
          end
          bCnt++;
          if (bValid && bReady) begin
            bDone = 1;
            if (resp == 2'b00) slaveMem[awAddrL[8:2]] = wDataL;
          end
        end
      end
      if (rReady && (wr || !arDone || rDone)) obsProto++;
      if (!wr) begin
        if (rDone) begin
          rValid = 0;
          rData = $urandom;
        end else if (arDone) begin
          if (rCnt >= rD) begin
            rValid = 1;
            rData = slaveMem[arAddrL[8:2]];
            rResp = resp;
          end
          rCnt++;
          if (rValid && rReady) rDone = 1;
        end
      end
      if (awValid) begin
        if (!wr || awDone) obsProto++;
        else begin
          if (awCnt == 0) awAddrL = awAddr;
          else if (awAddr !== awAddrL) obsProto++;
          obsAwHi++;
          if (awCnt >= awD) begin
            awReady = 1;
            awDone = 1;
          end
          awCnt++;
        end
      end else if (wr && awCnt > 0 && !awDone) obsProto++;
      if (wValid) begin
        if (!wr || wDone || wStrb !== 4'hF) obsProto++;
        else begin
          if (wCnt == 0) wDataL = wData;
          else if (wData !== wDataL) obsProto++;
          obsWHi++;
          if (wCnt >= wD) begin
            wReady = 1;
            wDone = 1;
          end
          wCnt++;
        end
      end else if (wr && wCnt > 0 && !wDone) obsProto++;
      if (arValid) begin
        if (wr || arDone) obsProto++;
        else begin
          if (arCnt == 0) arAddrL = arAddr;
          else if (arAddr !== arAddrL) obsProto++;
          obsArHi++;
          if (arCnt >= arD) begin
            arReady = 1;
            arDone = 1;
          end
          arCnt++;
        end
      end else if (!wr && arCnt > 0 && !arDone) obsProto++;
      if (rspValid) begin
        if (!rspSeen) begin
          rspSeen = 1;
          obsLat = c;
          snapData = rspRdata;
          snapResp = rspResp;
          obsHungRsp = statHung;
        end else if (rspRdata !== snapData || rspResp !== snapResp) obsProto++;
        if (holdCnt >= hold) begin
          rspReady = 1;
          fin = 1;
        end
        holdCnt++;
      end
      tick();
      c++;
    end
    rspReady = 0; awReady = 0; wReady = 0; arReady = 0; bValid = 0; rValid = 0;
    if (!fin) obsTimeout = 1;
    obsRspAfter = rspValid;
    obsCmdReadyAfter = cmdReady;
    obsRdata = snapData;
    obsResp = snapResp;
    obsAddr = wr ? awAddrL : arAddrL;
    obsWdata = wDataL;
  endtask

  // Reset values while reset is held, and command readiness once it is released.
  task automatic test_reset();
    areset = 1;
    repeat (3) tick();
    testsRun++;
    if ({cmdReady, awValid, wValid, bReady, arValid, rReady, rspValid} !== 7'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_handshakes: got %b expected 0000000", {cmdReady, awValid, wValid, bReady, arValid, rReady, rspValid});
    end
    testsRun++;
    if ({rspRdata, rspResp, statHung} !== 35'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_rsp: got rdata %h resp %b hung %b expected zeros", rspRdata, rspResp, statHung);
    end
    testsRun++;
    if ({awAddr, arAddr, wData} !== 96'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_addr_data: got aw %h ar %h wd %h expected zeros", awAddr, arAddr, wData);
    end
    areset = 0;
    tick();
    testsRun++;
    if (cmdReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", cmdReady);
    end
  endtask

  // Zero-wait write: address, strobe, data and minimum latency.
  task automatic test_write_zero_wait();
    applyStimulus(1, 7'h05, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2'b00, 0);
    refMem[7'h05] = 32'hDEADBEEF;
    testsRun++;
    if (obsTimeout !== 1'b0 || obsProto !== 0) begin
      testsFailed++;
      $display("[TB] FAIL zw_protocol: got timeout %b violations %0d expected 0 0", obsTimeout, obsProto);
    end
    testsRun++;
    if (obsLat !== 3) begin
      testsFailed++;
      $display("[TB] FAIL zw_latency: got %0d expected 3", obsLat);
    end
    testsRun++;
    if (obsAddr !== 32'h77A00014 || obsWdata !== 32'hDEADBEEF) begin
      testsFailed++;
      $display("[TB] FAIL zw_addr_data: got %h %h expected 77a00014 deadbeef", obsAddr, obsWdata);
    end
    testsRun++;
    if (obsRdata !== 32'd0 || obsResp !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL zw_rsp: got %h %b expected 00000000 00", obsRdata, obsResp);
    end
    testsRun++;
    if (obsRspAfter !== 1'b0 || obsCmdReadyAfter !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL zw_return_idle: got rsp %b ready %b expected 0 1", obsRspAfter, obsCmdReadyAfter);
    end
  endtask

  // Read of the top word with read data arriving three cycles late.
  task automatic test_read_delayed();
    refMem[7'h7F] = 32'h0000_0042;
    slaveMem[7'h7F] = 32'h0000_0042;
    applyStimulus(0, 7'h7F, 32'h0, 0, 0, 0, 0, 3, 2'b00, 0);
    testsRun++;
    if (obsTimeout !== 1'b0 || obsProto !== 0) begin
      testsFailed++;
      $display("[TB] FAIL rd_protocol: got timeout %b violations %0d expected 0 0", obsTimeout, obsProto);
    end
    testsRun++;
    if (obsAddr !== 32'h77A001FC) begin
      testsFailed++;
      $display("[TB] FAIL rd_araddr: got %h expected 77a001fc", obsAddr);
    end
    testsRun++;
    if (obsRdata !== 32'h42 || obsResp !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL rd_rsp: got %h %b expected 00000042 00", obsRdata, obsResp);
    end
    testsRun++;
    if (obsLat !== 6) begin
      testsFailed++;
      $display("[TB] FAIL rd_latency: got %0d expected 6", obsLat);
    end
  endtask

  // AW and W handshakes in either order or together; each VALID lasts until its own handshake.
  task automatic test_write_order();
    int awD [3] = '{2, 1, 0};
    int wD  [3] = '{0, 1, 3};
    for (int i = 0; i < 3; i++) begin
      int longest;
      longest = (awD[i] > wD[i]) ? awD[i] : wD[i];
      applyStimulus(1, 7'(10 + i), 32'hA5A50000 + 32'(i), awD[i], wD[i], 0, 0, 0, 2'b00, 0);
      if (obsResp == 2'b00) refMem[10 + i] = 32'hA5A50000 + 32'(i);
      testsRun++;
      if (obsTimeout !== 1'b0 || obsProto !== 0 || obsRspAfter !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL order_protocol_%0d: got timeout %b violations %0d rsp_after %b expected 0 0 0", i, obsTimeout, obsProto, obsRspAfter);
      end
      testsRun++;
      if (obsAwHi !== awD[i] + 1 || obsWHi !== wD[i] + 1) begin
        testsFailed++;
        $display("[TB] FAIL order_valid_len_%0d: got aw %0d w %0d expected %0d %0d", i, obsAwHi, obsWHi, awD[i] + 1, wD[i] + 1);
      end
      testsRun++;
      if (obsLat !== 3 + longest) begin
        testsFailed++;
        $display("[TB] FAIL order_latency_%0d: got %0d expected %0d", i, obsLat, 3 + longest);
      end
    end
  endtask

  // Error responses pass through; a stalled response holds still and blocks new commands.
  task automatic test_error_hold();
    applyStimulus(1, 7'h20, 32'h12345678, 0, 0, 0, 0, 0, 2'b10, 5);
    testsRun++;
    if (obsResp !== 2'b10 || obsRdata !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL slverr_rsp: got %b %h expected 10 00000000", obsResp, obsRdata);
    end
    testsRun++;
    if (obsTimeout !== 1'b0 || obsProto !== 0) begin
      testsFailed++;
      $display("[TB] FAIL slverr_hold: got timeout %b violations %0d expected 0 0", obsTimeout, obsProto);
    end
    applyStimulus(0, 7'h05, 32'h0, 1, 1, 1, 1, 1, 2'b11, 2);
    testsRun++;
    if (obsResp !== 2'b11 || obsRdata !== refMem[7'h05]) begin
      testsFailed++;
      $display("[TB] FAIL decerr_rsp: got %b %h expected 11 %h", obsResp, obsRdata, refMem[7'h05]);
    end
  endtask

  // Hang flag sets exactly after the limit of stalled cycles, is sticky, and clears on accept.
  task automatic test_hang();
    int arD [3] = '{7, 8, 10};
    for (int i = 0; i < 3; i++) begin
      int expFirst;
      expFirst = (arD[i] >= HANG_LIMIT) ? HANG_LIMIT + 1 : -1;
      applyStimulus(0, 7'h7F, 32'h0, 0, 0, 0, arD[i], 0, 2'b00, 0);
      testsRun++;
      if (obsHungFirst !== expFirst || obsHungRsp !== (arD[i] >= HANG_LIMIT)) begin
        testsFailed++;
        $display("[TB] FAIL hang_flag_%0d: got first %0d at_rsp %b expected %0d %b", arD[i], obsHungFirst, obsHungRsp, expFirst, arD[i] >= HANG_LIMIT);
      end
      testsRun++;
      if (obsArHi !== arD[i] + 1 || obsProto !== 0 || obsTimeout !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL hang_arvalid_%0d: got high %0d violations %0d timeout %b expected %0d 0 0", arD[i], obsArHi, obsProto, obsTimeout, arD[i] + 1);
      end
    end
    tick();
    testsRun++;
    if (statHung !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL hang_sticky: got %b expected 1", statHung);
    end
    applyStimulus(1, 7'h30, 32'hCAFEF00D, 0, 0, 0, 0, 0, 2'b00, 0);
    refMem[7'h30] = 32'hCAFEF00D;
    testsRun++;
    if (obsHungC1 !== 1'b0 || obsHungRsp !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL hang_clear: got %b %b expected 0 0", obsHungC1, obsHungRsp);
    end
  endtask

  // Reset while waiting for the write response abandons the write cleanly.
  task automatic test_reset_mid();
    int c;
    c = 0;
    while (!cmdReady && c < 20) begin
      tick();
      c++;
    end
    cmdValid = 1; cmdWrite = 1; cmdOffset = 7'h03; cmdWdata = 32'hBADBAD00;
    tick();
    cmdValid = 0; cmdWrite = 0;
    awReady = 1; wReady = 1;
    tick();
    awReady = 0; wReady = 0;
    testsRun++;
    if (bReady !== 1'b1 || awValid !== 1'b0 || wValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_bwait: got bready %b aw %b w %b expected 1 0 0", bReady, awValid, wValid);
    end
    areset = 1;
    tick();
    testsRun++;
    if ({cmdReady, awValid, wValid, bReady, arValid, rReady, rspValid} !== 7'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset_handshakes: got %b expected 0000000", {cmdReady, awValid, wValid, bReady, arValid, rReady, rspValid});
    end
    areset = 0;
    tick();
    testsRun++;
    if (cmdReady !== 1'b1 || rspValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_release: got ready %b rsp %b expected 1 0", cmdReady, rspValid);
    end
    applyStimulus(0, 7'h03, 32'h0, 0, 0, 0, 0, 0, 2'b00, 0);
    testsRun++;
    if (obsRdata !== refMem[7'h03] || obsTimeout !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL mid_write_lost: got %h timeout %b expected %h 0", obsRdata, obsTimeout, refMem[7'h03]);
    end
  endtask

  // Random commands, stalls and response codes against the word-memory reference.
  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit wr;
      logic [6:0] off;
      logic [31:0] data, expData, expAddr;
      logic [1:0] resp;
      int d [5];
      int hold, expLat, longest;
      bit expHung;
      wr = 1'($urandom_range(0, 1));
      off = 7'($urandom);
      data = $urandom;
      resp = 2'($urandom_range(0, 3));
      hold = $urandom_range(0, 3);
      for (int k = 0; k < 5; k++) begin
        d[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 10) : $urandom_range(0, 2);
      end
      longest = (d[0] > d[1]) ? d[0] : d[1];
      expLat  = wr ? 3 + longest + d[2] : 3 + d[3] + d[4];
      expHung = wr ? (longest >= HANG_LIMIT || d[2] >= HANG_LIMIT)
                   : (d[3] >= HANG_LIMIT || d[4] >= HANG_LIMIT);
      expData = wr ? 32'd0 : refMem[off];
      expAddr = BASE | ({25'd0, off} << 2);
      applyStimulus(wr, off, data, d[0], d[1], d[2], d[3], d[4], resp, hold);
      if (wr && resp == 2'b00) refMem[off] = data;
      testsRun++;
      if (obsTimeout !== 1'b0 || obsProto !== 0) begin
        testsFailed++;
        $display("[TB] FAIL rand_protocol_%0d: got timeout %b violations %0d expected 0 0", i, obsTimeout, obsProto);
      end
      testsRun++;
      if (obsLat !== expLat || obsAddr !== expAddr) begin
        testsFailed++;
        $display("[TB] FAIL rand_lat_addr_%0d: got %0d %h expected %0d %h", i, obsLat, obsAddr, expLat, expAddr);
      end
      testsRun++;
      if (obsRdata !== expData || obsResp !== resp) begin
        testsFailed++;
        $display("[TB] FAIL rand_rsp_%0d: got %h %b expected %h %b", i, obsRdata, obsResp, expData, resp);
      end
      testsRun++;
      if (obsHungRsp !== expHung || obsHungC1 !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL rand_hung_%0d: got %b c1 %b expected %b 0", i, obsHungRsp, obsHungC1, expHung);
      end
    end
  endtask

  initial begin
    areset = 1;
    cmdValid = 0; cmdWrite = 0; cmdOffset = '0; cmdWdata = '0; rspReady = 0;
    awReady = 0; wReady = 0; arReady = 0;
    bValid = 0; bResp = '0; rValid = 0; rResp = '0; rData = '0;
    for (int i = 0; i < 128; i++) begin
      refMem[i] = $urandom;
      slaveMem[i] = refMem[i];
    end
    test_reset();
    test_write_zero_wait();
    test_read_delayed();
    test_write_order();
    test_error_hold();
    test_hang();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by 500000 expected earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
